// File: rtl/cyq_tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer receive path.
//   state_t       : frame-alignment state (HUNT / DATA / CHECK)
//   SYNC_WORD_DEF : default frame sync pattern
//   clog2()       : width helper, never returns less than 1
//   CNT_W         : bit counter width for the default 8-bit word / 8-bit sync
package cyq_tdm_pkg;

  typedef enum logic [1:0] {HUNT, DATA, CHECK} state_t;

  localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int CNT_W = clog2(8);

endpackage

// File: rtl/cyq_tdm_if.sv
// Serial-in / parallel-out bundle of the TDM demultiplexer.
//   sdi, sdi_en : serial line and its bit strobe (driven by the link side)
//   ch_data     : CH_NUM packed channel words, channel k at [k*DATA_W +: DATA_W]
//   ch_wr       : one-hot load pulse, frame_done / sync_err : one-cycle pulses
//   ch_sel      : channel being shifted in, locked : frame alignment held
// mst = link / bench side, slv = demultiplexer side.
interface cyq_tdm_if #(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 8
);
  localparam int SEL_W = cyq_tdm_pkg::clog2(CH_NUM);

  logic                       sdi;
  logic                       sdi_en;
  logic [CH_NUM*DATA_W-1:0]   ch_data;
  logic [CH_NUM-1:0]          ch_wr;
  logic [SEL_W-1:0]           ch_sel;
  logic                       frame_done;
  logic                       locked;
  logic                       sync_err;

  modport mst (
    output sdi, sdi_en,
    input  ch_data, ch_wr, ch_sel, frame_done, locked, sync_err
  );

  modport slv (
    input  sdi, sdi_en,
    output ch_data, ch_wr, ch_sel, frame_done, locked, sync_err
  );
endinterface

// File: rtl/cyq_onehot_dec.sv
// N-to-2^N enable decoder (138-style): o_dec[i_sel] follows i_en, all other
// outputs low. Used to turn the channel pointer plus a word-complete strobe
// into per-slice load enables.
//   i_sel : binary select, i_en : enable, o_dec : one-hot output
module cyq_onehot_dec
  import cyq_tdm_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]        i_sel,
  input  logic                i_en,
  output logic [(1<<N)-1:0]   o_dec
);

  always_comb begin
    o_dec = '0;
    for (int k = 0; k < (1 << N); k++) begin
      if (i_en && (i_sel == N'(k))) o_dec[k] = 1'b1;
    end
  end

endmodule

// File: rtl/cyq_tdm_demux.sv
// TDM demultiplexer, receive side of the serial data-selector link.
// Hunts for SYNC_WORD on the line, then shifts CH_NUM words of DATA_W bits
// into the channel registers, then re-checks the sync word (no sliding)
// before the next frame. A failed re-check drops lock and resumes hunting.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cyq_tdm_if slave modport (serial in, channel outputs)
module cyq_tdm_demux
  import cyq_tdm_pkg::*;
#(
  parameter int                CH_NUM    = 4,
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEF)
) (
  input  logic   clk,
  input  logic   rst,
  cyq_tdm_if.slv bus
);

  localparam int SEL_W = clog2(CH_NUM);
  localparam int BC_W  = clog2((DATA_W > SYNC_W) ? DATA_W : SYNC_W);

  state_t                         r_state;
  // Only the older bits are stored; the newest bit comes straight off sdi.
  logic [SYNC_W-2:0]              r_win;
  logic [DATA_W-2:0]              r_word;
  logic [BC_W-1:0]                r_cnt;
  logic [SEL_W-1:0]               r_sel;
  logic [CH_NUM-1:0][DATA_W-1:0]  r_data;
  logic [CH_NUM-1:0]              r_wr;
  logic                           r_fd;
  logic                           r_locked;
  logic                           r_serr;

  logic [SYNC_W-1:0]              w_win_nxt;
  logic [DATA_W-1:0]              w_word_nxt;
  logic                           w_last_data;
  logic                           w_last_sync;
  logic                           w_word_done;
  logic [CH_NUM-1:0]              w_ld;

  assign w_win_nxt   = {r_win, bus.sdi};
  assign w_word_nxt  = {r_word, bus.sdi};
  assign w_last_data = (r_cnt == BC_W'(DATA_W - 1));
  assign w_last_sync = (r_cnt == BC_W'(SYNC_W - 1));
  assign w_word_done = bus.sdi_en && (r_state == DATA) && w_last_data;

  cyq_onehot_dec #(.N(SEL_W)) u_dec (
    .i_sel (r_sel),
    .i_en  (w_word_done),
    .o_dec (w_ld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= HUNT;
      r_win    <= '0;
      r_word   <= '0;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_data   <= '0;
      r_wr     <= '0;
      r_fd     <= 1'b0;
      r_locked <= 1'b0;
      r_serr   <= 1'b0;
    end else begin
      // Pulses default low every cycle, enabled bit or not.
      r_wr   <= w_ld;
      r_fd   <= 1'b0;
      r_serr <= 1'b0;
      for (int k = 0; k < CH_NUM; k++) begin
        if (w_ld[k]) r_data[k] <= w_word_nxt;
      end
      if (bus.sdi_en) begin
        case (r_state)
          HUNT: begin
            r_win <= w_win_nxt[SYNC_W-2:0];
            if (w_win_nxt == SYNC_WORD) begin
              r_state  <= DATA;
              r_sel    <= '0;
              r_cnt    <= '0;
              r_locked <= 1'b1;
            end
          end
          DATA: begin
            r_word <= w_word_nxt[DATA_W-2:0];
            if (w_last_data) begin
              r_cnt <= '0;
              if (r_sel == SEL_W'(CH_NUM - 1)) begin
                r_fd    <= 1'b1;
                r_sel   <= '0;
                r_state <= CHECK;
              end else begin
                r_sel <= r_sel + SEL_W'(1);
              end
            end else begin
              r_cnt <= r_cnt + BC_W'(1);
            end
          end
          CHECK: begin
            // Fixed SYNC_W-bit slot: after SYNC_W shifts the window holds
            // only this slot's bits, so no pre-clear is needed.
            r_win <= w_win_nxt[SYNC_W-2:0];
            if (w_last_sync) begin
              r_cnt <= '0;
              if (w_win_nxt == SYNC_WORD) begin
                r_state <= DATA;
              end else begin
                r_serr   <= 1'b1;
                r_locked <= 1'b0;
                r_win    <= '0;
                r_state  <= HUNT;
              end
            end else begin
              r_cnt <= r_cnt + BC_W'(1);
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign bus.ch_data    = r_data;
  assign bus.ch_wr      = r_wr;
  assign bus.ch_sel     = r_sel;
  assign bus.frame_done = r_fd;
  assign bus.locked     = r_locked;
  assign bus.sync_err   = r_serr;

endmodule

// File: tb/tb_cyq_tdm_demux.sv
// Bench for cyq_tdm_demux: table of whole-stream vectors, hand-written
// corner sequences, randomized streams against a frame-level model, and a
// small-parameter instance (2 ch x 4 bit, sync 4'h9).
module tb_cyq_tdm_demux;
  import cyq_tdm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cyq_tdm_if #(.CH_NUM(4), .DATA_W(8)) ifa ();
  cyq_tdm_if #(.CH_NUM(2), .DATA_W(4)) ifb ();

  cyq_tdm_demux #(.CH_NUM(4), .DATA_W(8), .SYNC_W(8), .SYNC_WORD(8'hA5)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  cyq_tdm_demux #(.CH_NUM(2), .DATA_W(4), .SYNC_W(4), .SYNC_WORD(4'h9)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Frame-level model of the 4x8 instance: mode 0 hunt, 1 data, 2 check.
  int         m_mode, m_hist, m_n, m_acc, m_ch, m_wr;
  bit         m_fd, m_serr, m_locked;
  logic [7:0] m_data [4];

  function automatic void m_reset();
    m_mode = 0; m_hist = 0; m_n = 0; m_acc = 0; m_ch = 0; m_wr = -1;
    m_fd = 0; m_serr = 0; m_locked = 0;
    for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
  endfunction

  function automatic void m_step(bit en, bit b);
    m_wr = -1; m_fd = 0; m_serr = 0;
    if (!en) return;
    case (m_mode)
      0: begin
        m_hist = (m_hist * 2 + int'(b)) % 256;
        if (m_hist == 'hA5) begin
          m_mode = 1; m_n = 0; m_acc = 0; m_ch = 0; m_locked = 1;
        end
      end
      1: begin
        m_acc = m_acc * 2 + int'(b); m_n++;
        if (m_n == 8) begin
          m_data[m_ch] = m_acc[7:0]; m_wr = m_ch; m_n = 0; m_acc = 0;
          if (m_ch == 3) begin m_fd = 1; m_ch = 0; m_mode = 2; end
          else m_ch++;
        end
      end
      default: begin
        m_acc = m_acc * 2 + int'(b); m_n++;
        if (m_n == 8) begin
          if (m_acc == 'hA5) m_mode = 1;
          else begin m_serr = 1; m_locked = 0; m_hist = 0; m_mode = 0; end
          m_n = 0; m_acc = 0;
        end
      end
    endcase
  endfunction

  task automatic cmp_a();
    logic [31:0] ed;
    logic [3:0]  ew;
    ed = {m_data[3], m_data[2], m_data[1], m_data[0]};
    ew = (m_wr < 0) ? 4'b0000 : 4'(1 << m_wr);
    chk("ch_data",    64'(ifa.ch_data),    64'(ed));
    chk("ch_wr",      64'(ifa.ch_wr),      64'(ew));
    chk("ch_sel",     64'(ifa.ch_sel),     64'(m_ch[1:0]));
    chk("frame_done", 64'(ifa.frame_done), 64'(m_fd));
    chk("locked",     64'(ifa.locked),     64'(m_locked));
    chk("sync_err",   64'(ifa.sync_err),   64'(m_serr));
  endtask

  task automatic tick(bit en, bit b);
    ifa.sdi_en = en;
    ifa.sdi    = b;
    @(posedge clk);
    if (rst) m_reset();
    else m_step(en, b);
    #1;
    cmp_a();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] v, int gap);
    for (int i = 7; i >= 0; i--) begin
      repeat (gap) tick(1'b0, 1'($urandom));
      tick(1'b1, v[i]);
    end
  endtask

  typedef struct {
    logic [63:0] bits;
    int          len;
    int          gap;
    logic [31:0] exp_data;
    bit          exp_locked;
  } vec_t;

  vec_t vt [6];

  initial begin
    m_reset();
    ifa.sdi_en = 1'b0; ifa.sdi = 1'b0;
    ifb.sdi_en = 1'b0; ifb.sdi = 1'b0;

    vt[0] = '{64'hA511223344,     40, 0, 32'h44332211, 1'b1};
    vt[1] = '{64'h3CA501020304,   48, 0, 32'h04030201, 1'b1};
    // one stray 1 then A5 A5: lock on the first A5, second A5 becomes ch0,
    // 44 lands in the sync slot and drops lock
    vt[2] = '{64'h1A5A511223344,  49, 0, 32'h332211A5, 1'b0};
    vt[3] = '{64'hA511223344,     40, 2, 32'h44332211, 1'b1};
    vt[4] = '{64'hA511223344A4,   48, 0, 32'h44332211, 1'b0};
    vt[5] = '{64'hA511223344A5,   48, 0, 32'h44332211, 1'b1};

    // reset state
    do_reset();
    chk("rst_data",   64'(ifa.ch_data), 64'h0);
    chk("rst_locked", 64'(ifa.locked),  64'h0);

    // table-driven streams
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = vt[v].len - 1; i >= 0; i--) begin
        repeat (vt[v].gap) tick(1'b0, 1'($urandom));
        tick(1'b1, vt[v].bits[i]);
      end
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      chk($sformatf("vec%0d_data", v),   64'(ifa.ch_data), 64'(vt[v].exp_data));
      chk($sformatf("vec%0d_locked", v), 64'(ifa.locked),  64'(vt[v].exp_locked));
    end

    // lock timing and write latency
    do_reset();
    for (int i = 7; i >= 1; i--) tick(1'b1, 1'(8'hA5 >> i));
    chk("lock_early", 64'(ifa.locked), 64'h0);
    tick(1'b1, 1'b1);
    chk("lock_8th", 64'(ifa.locked), 64'h1);
    send_byte(8'h11, 0);
    chk("wr_ch0", 64'(ifa.ch_wr), 64'b0001);
    tick(1'b0, 1'b0);
    chk("wr_ch0_off", 64'(ifa.ch_wr), 64'b0000);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    chk("wr_ch3", 64'(ifa.ch_wr), 64'b1000);
    chk("fd_ch3", 64'(ifa.frame_done), 64'h1);
    chk("frame1", 64'(ifa.ch_data), 64'h44332211);

    // bad sync word, then relock
    send_byte(8'hA4, 0);
    chk("serr_pulse", 64'(ifa.sync_err), 64'h1);
    chk("serr_unlock", 64'(ifa.locked), 64'h0);
    chk("serr_hold", 64'(ifa.ch_data), 64'h44332211);
    tick(1'b0, 1'b0);
    chk("serr_off", 64'(ifa.sync_err), 64'h0);
    send_byte(8'hA5, 0);
    chk("relock", 64'(ifa.locked), 64'h1);
    send_byte(8'h55, 1); send_byte(8'h66, 0); send_byte(8'h77, 2); send_byte(8'h88, 0);
    chk("frame2", 64'(ifa.ch_data), 64'h88776655);

    // reset mid-frame (after bit 5 of channel 2)
    do_reset();
    send_byte(8'hA5, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    for (int i = 7; i >= 3; i--) tick(1'b1, 1'(8'h33 >> i));
    do_reset();
    chk("mid_rst_data", 64'(ifa.ch_data), 64'h0);
    chk("mid_rst_sel",  64'(ifa.ch_sel),  64'h0);
    chk("mid_rst_lock", 64'(ifa.locked),  64'h0);
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    chk("mid_rst_frame", 64'(ifa.ch_data), 64'h04030201);

    // randomized streams, model compared every cycle
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [7:0] byt;
      byt = ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom);
      for (int i = 7; i >= 0; i--) begin
        repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom));
        tick(1'b1, byt[i]);
      end
    end

    // small-parameter instance: 9, A, B at full rate
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      logic [11:0] s;
      s = 12'h9AB;
      ifb.sdi_en = 1'b1;
      ifb.sdi    = s[12 - i];
      tick(1'b0, 1'b0);
      chk($sformatf("b_fd_%0d", i), 64'(ifb.frame_done), 64'(i == 12));
      if (i == 3)  chk("b_lock_early", 64'(ifb.locked), 64'h0);
      if (i == 4)  chk("b_lock", 64'(ifb.locked), 64'h1);
      if (i == 8)  chk("b_wr0", 64'(ifb.ch_wr), 64'b01);
      if (i == 12) chk("b_wr1", 64'(ifb.ch_wr), 64'b10);
    end
    ifb.sdi_en = 1'b0;
    tick(1'b0, 1'b0);
    chk("b_data", 64'(ifb.ch_data), 64'hBA);
    chk("b_wr_off", 64'(ifb.ch_wr), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
